// File: rtl/axi_4_lite_pkg.sv
// Shared constants for the AXI4-Lite register slave: response codes and register file size.
// No logic; imported by the slave top.
// No flow control of its own.
package axi_4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

endpackage

// File: rtl/axil_sync_fifo.sv
// Single-clock FIFO used as a response queue.
// Latency: pushed entry visible at pop_dat one cycle after the push edge.
// Backpressure: push ignored while full (even if popping that cycle); pop ignored while empty.
module axil_sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; consumers mask pop_dat while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/axi_4_lite_slave.sv
// AXI4-Lite slave with 16 x 32-bit registers; AXIL_ADDR_DECODE_ERR_EN adds SLVERR for addr >= 0x40.
// Latency: B/R response valid one cycle after the accepting edge.
// Backpressure: AW/W/AR ready drop when the matching response queue is full or during reset.
module axi_4_lite_slave
    import axi_4_lite_pkg::*;
#(
    parameter int ADDRESS           = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int WRITE_QUEUE_DEPTH = 4,
    parameter int READ_QUEUE_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDRESS-1:0]    S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_WDATA,
    input  logic [3:0]            S_WSTRB,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    input  logic                  S_BREADY,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic [ADDRESS-1:0]    S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    input  logic                  S_RREADY,
    output logic [DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID
);

    localparam int RQW = DATA_WIDTH + 2;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [REG_IDX_W-1:0]  wr_idx;
    logic [REG_IDX_W-1:0]  rd_idx;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_err;
    logic                  rd_err;
    logic                  b_full, b_empty;
    logic                  r_full, r_empty;
    logic [1:0]            b_head;
    logic [1:0]            b_push_dat;
    logic [RQW-1:0]        r_head;
    logic [RQW-1:0]        r_push_dat;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  addr_unused;

    assign wr_idx      = S_AWADDR[5:2];
    assign rd_idx      = S_ARADDR[5:2];
    assign addr_unused = ^{S_AWADDR, S_ARADDR};

`ifdef AXIL_ADDR_DECODE_ERR_EN
    assign wr_err = (S_AWADDR >> 6) != '0;
    assign rd_err = (S_ARADDR >> 6) != '0;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // AW and W share one ready so the two channels are only ever taken together.
    assign S_AWREADY = ~b_full & ~RESET;
    assign S_WREADY  = ~b_full & ~RESET;
    assign S_ARREADY = ~r_full & ~RESET;

    assign wr_acc = S_AWVALID & S_WVALID & S_AWREADY;
    assign rd_acc = S_ARVALID & S_ARREADY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_acc && !wr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (S_WSTRB[b]) regs[wr_idx][8*b +: 8] <= S_WDATA[8*b +: 8];
            end
        end
    end

    // Read samples the register array before any same-edge write lands.
    assign rd_data    = rd_err ? '0 : regs[rd_idx];
    assign r_push_dat = {(rd_err ? RESP_SLVERR : RESP_OKAY), rd_data};
    assign b_push_dat = wr_err ? RESP_SLVERR : RESP_OKAY;

    axil_sync_fifo #(.WIDTH(2), .DEPTH(WRITE_QUEUE_DEPTH)) u_bq (
        .clk      (CLK),
        .reset    (RESET),
        .push     (wr_acc),
        .push_dat (b_push_dat),
        .pop      (S_BVALID & S_BREADY),
        .pop_dat  (b_head),
        .full     (b_full),
        .empty    (b_empty)
    );

    axil_sync_fifo #(.WIDTH(RQW), .DEPTH(READ_QUEUE_DEPTH)) u_rq (
        .clk      (CLK),
        .reset    (RESET),
        .push     (rd_acc),
        .push_dat (r_push_dat),
        .pop      (S_RVALID & S_RREADY),
        .pop_dat  (r_head),
        .full     (r_full),
        .empty    (r_empty)
    );

    assign S_BVALID = ~b_empty;
    assign S_BRESP  = b_empty ? RESP_OKAY : b_head;
    assign S_RVALID = ~r_empty;
    assign S_RDATA  = r_empty ? '0 : r_head[DATA_WIDTH-1:0];
    assign S_RRESP  = r_empty ? RESP_OKAY : r_head[DATA_WIDTH+1:DATA_WIDTH];

endmodule

// File: tb/tb_axi_4_lite_slave.sv
// Directed bench for axi_4_lite_slave: hand-computed vectors checked with immediate assertions.
module tb_axi_4_lite_slave;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] S_AWADDR;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WVALID;
    logic        S_WREADY;
    logic        S_BREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic [31:0] S_ARADDR;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic        S_RREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;

    int n_cmp = 0;
    int n_err = 0;

    axi_4_lite_slave dut (
        .CLK(CLK), .RESET(RESET),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BREADY(S_BREADY), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0; S_ARADDR = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_awready", S_AWREADY, 0);
        chk("rst_arready", S_ARREADY, 0);
        chk("rst_bvalid", S_BVALID, 0);
        chk("rst_rvalid", S_RVALID, 0);
        chk("rst_rdata", S_RDATA, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rel_awready", S_AWREADY, 1);
        chk("rel_wready", S_WREADY, 1);
        chk("rel_arready", S_ARREADY, 1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge CLK);
        S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        while (!(S_AWREADY && S_WREADY) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("aw_w_accept", (n < 50), 1);
        @(negedge CLK);
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
    endtask

    task automatic axi_read_issue(input logic [31:0] a);
        int n = 0;
        @(negedge CLK);
        S_ARADDR = a; S_ARVALID = 1'b1;
        while (!S_ARREADY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("ar_accept", (n < 50), 1);
        @(negedge CLK);
        S_ARVALID = 1'b0;
    endtask

    task automatic get_b(input logic [1:0] exp, input string tag);
        int n = 0;
        while (!S_BVALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_bvalid"}, S_BVALID, 1);
        chk({tag, "_bresp"}, S_BRESP, exp);
        S_BREADY = 1'b1;
        @(negedge CLK);
        S_BREADY = 1'b0;
    endtask

    task automatic get_r(input logic [31:0] exp_d, input logic [1:0] exp_r, input string tag);
        int n = 0;
        while (!S_RVALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_rvalid"}, S_RVALID, 1);
        chk({tag, "_rdata"}, S_RDATA, exp_d);
        chk({tag, "_rresp"}, S_RRESP, exp_r);
        S_RREADY = 1'b1;
        @(negedge CLK);
        S_RREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_d,
                            input logic [1:0] exp_r, input string tag);
        axi_read_issue(a);
        get_r(exp_d, exp_r, tag);
    endtask

    initial begin
        RESET = 1'b1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0; S_ARADDR = '0;

        // Basic full-word write/read with one-cycle response latency
        do_reset();
        axi_write(32'h00, 32'h12345678, 4'b1111);
        chk("b_latency", S_BVALID, 1);
        get_b(2'b00, "w0");
        chk("b_drained", S_BVALID, 0);
        axi_read_issue(32'h00);
        chk("r_latency", S_RVALID, 1);
        get_r(32'h12345678, 2'b00, "r0");

        // Byte strobes
        do_reset();
        axi_write(32'h04, 32'hAABBCCDD, 4'b1010);
        get_b(2'b00, "wstrb");
        axi_read(32'h04, 32'hAA00CC00, 2'b00, "rstrb");

        // Fill write response queue, then show it blocks even with a pop pending
        for (int i = 0; i < 4; i++) axi_write(32'h30 + 32'(4 * i), 32'h600DF00D + 32'(i), 4'b1111);
        chk("bq_full_awready", S_AWREADY, 0);
        chk("bq_full_wready", S_WREADY, 0);
        S_AWADDR = 32'h00; S_WDATA = 32'hBAD0BAD0; S_WSTRB = 4'b1111;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        @(negedge CLK);
        chk("fifth_blocked", S_AWREADY, 0);
        chk("fill_bresp0", S_BRESP, 2'b00);
        S_BREADY = 1'b1;
        chk("full_pop_awready", S_AWREADY, 0);
        @(negedge CLK);
        S_BREADY = 1'b0; S_AWVALID = 1'b0; S_WVALID = 1'b0;
        chk("after_pop_awready", S_AWREADY, 1);
        for (int i = 1; i < 4; i++) get_b(2'b00, "fill");
        chk("fill_drained", S_BVALID, 0);

        // Fill read queue and drain in order
        for (int i = 0; i < 4; i++) axi_read_issue(32'h30 + 32'(4 * i));
        chk("rq_full_arready", S_ARREADY, 0);
        get_r(32'h600DF00D, 2'b00, "rd30");
        get_r(32'h600DF00E, 2'b00, "rd34");
        get_r(32'h600DF00F, 2'b00, "rd38");
        get_r(32'h600DF010, 2'b00, "rd3c");
        axi_read(32'h00, 32'h00000000, 2'b00, "rd00_untouched");

        // Concurrent write and read
        axi_write(32'h10, 32'hFEEDFACE, 4'b1111);
        get_b(2'b00, "w10");
        @(negedge CLK);
        S_AWADDR = 32'h28; S_WDATA = 32'h55555555; S_WSTRB = 4'b1111;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        S_ARADDR = 32'h10; S_ARVALID = 1'b1;
        chk("sim_awready", S_AWREADY, 1);
        chk("sim_arready", S_ARREADY, 1);
        @(negedge CLK);
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        get_b(2'b00, "sim");
        get_r(32'hFEEDFACE, 2'b00, "sim");

        // Same-register collision returns the old value
        @(negedge CLK);
        S_AWADDR = 32'h28; S_WDATA = 32'h11111111; S_WSTRB = 4'b1111;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        S_ARADDR = 32'h28; S_ARVALID = 1'b1;
        @(negedge CLK);
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        get_b(2'b00, "coll");
        get_r(32'h55555555, 2'b00, "coll_old");
        axi_read(32'h2A, 32'h11111111, 2'b00, "coll_new");

        // Out-of-range address
        axi_write(32'h1030, 32'hDEADBEEF, 4'b1111);
`ifdef AXIL_ADDR_DECODE_ERR_EN
        get_b(2'b10, "oor");
        axi_read(32'h1030, 32'h00000000, 2'b10, "oor");
        axi_read(32'h30, 32'h600DF00D, 2'b00, "oor_reg30");
`else
        get_b(2'b00, "alias");
        axi_read(32'h1030, 32'hDEADBEEF, 2'b00, "alias");
        axi_read(32'h30, 32'hDEADBEEF, 2'b00, "alias_reg30");
`endif

        // Reset with responses pending
        axi_write(32'h08, 32'hCAFEBABE, 4'b1111);
        axi_read_issue(32'h08);
        chk("pend_bvalid", S_BVALID, 1);
        chk("pend_rvalid", S_RVALID, 1);
        do_reset();
        chk("post_rst_bvalid", S_BVALID, 0);
        chk("post_rst_rvalid", S_RVALID, 0);
        chk("post_rst_bresp", S_BRESP, 0);
        for (int i = 0; i < 16; i++) axi_read(32'(4 * i), 32'h0, 2'b00, "post_rst_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
